muldiv_iter_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_div_iter.sv | 89 ++++++++
 rtl/muldiv_iter_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, FSM states and helpers for the RV M-extension
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_e;

    typedef struct packed {
        logic is_rem;
        logic q_neg;
        logic r_neg;
        logic special;
    } div_ctl_t;

    // Most-negative / -1 detection for an xlen-wide operand pair.
    function automatic logic is_signed_ovf(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned xlen
    );
        logic [63:0] min_neg;
        logic [63:0] all_ones;
        min_neg  = 64'd1 << (xlen - 1);
        all_ones = (xlen >= 64) ? '1 : ((64'd1 << xlen) - 64'd1);
        return (a == min_neg) && (b == all_ones);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit
// per cycle, XLEN steps after start.
module muldiv_div_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // quo_q doubles as the dividend shift register
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = done_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        if (clear_i) begin
            active_d = 1'b0;
            done_d   = 1'b0;
        end else if (start_i) begin
            active_d = 1'b1;
            done_d   = 1'b0;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = dividend_i;
            dvs_d    = divisor_i;
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
            if (trial[XLEN]) begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            if (cnt_q == CW'(XLEN - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_iter_unit.sv
// RV32M/RV64M multiply/divide unit: fixed-latency multiply, iterative divide.
// Define MULDIV_DIV_EARLY_OUT_EN to finish trivial/special divides in one cycle.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    input  logic [2:0]       funct3_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] resp_tag_o
);

    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int PW  = 2 * XLEN + 2;

    muldiv_state_e state_q, state_d;

    logic                   accept, div_req, div_start;
    logic                   mul_fire, div_fire, div_done, div_early;
    logic                   sgn_div, s1, s2, dz, ovf, trivial;
    logic [XLEN-1:0]        mag1, mag2, special_res;
    logic [XLEN-1:0]        quo, rem, quo_fix, rem_fix, div_res;
    logic signed [XLEN:0]   ma_d, mb_d, ma_q, mb_q;
    logic signed [PW-1:0]   prod;
    logic                   unused_prod;
    logic                   mhi_q;
    logic [MCW-1:0]         mcnt_q;
    div_ctl_t               dctl_d, dctl_q;
    logic [XLEN-1:0]        sres_q, result_q;
    logic [TAG_W-1:0]       tag_q;

    assign accept  = req_valid_i & req_ready_o;
    assign div_req = funct3_i[2];
    assign sgn_div = ~funct3_i[0];
    assign s1      = sgn_div & op1_i[XLEN-1];
    assign s2      = sgn_div & op2_i[XLEN-1];
    assign mag1    = s1 ? -op1_i : op1_i;
    assign mag2    = s2 ? -op2_i : op2_i;
    assign dz      = (op2_i == '0);
    assign ovf     = sgn_div & is_signed_ovf(64'(op1_i), 64'(op2_i), XLEN);

`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign trivial   = (mag1 < mag2);
    assign div_early = dctl_q.special;
`else
    assign trivial   = 1'b0;
    assign div_early = 1'b0;
`endif

    // dz, ovf and trivial are mutually exclusive by construction
    always_comb begin
        special_res = '0;
        unique case (1'b1)
            dz:      special_res = funct3_i[1] ? op1_i : '1;
            ovf:     special_res = funct3_i[1] ? '0 : op1_i;
            trivial: special_res = funct3_i[1] ? op1_i : '0;
            default: special_res = '0;
        endcase
    end

    assign dctl_d = '{
        is_rem:  funct3_i[1],
        q_neg:   s1 ^ s2,
        r_neg:   s1,
        special: dz | ovf | trivial
    };

    assign ma_d = {(funct3_i != FUNCT3_MULHU) & op1_i[XLEN-1], op1_i};
    assign mb_d = {((funct3_i == FUNCT3_MUL) |
                    (funct3_i == FUNCT3_MULH)) & op2_i[XLEN-1], op2_i};
    assign prod = PW'(ma_q) * PW'(mb_q);
    assign unused_prod = ^prod[PW-1:2*XLEN];

    muldiv_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .start_i    (div_start),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .done_o     (div_done),
        .quotient_o (quo),
        .remainder_o(rem)
    );

    assign quo_fix = dctl_q.q_neg ? -quo : quo;
    assign rem_fix = dctl_q.r_neg ? -rem : rem;
    assign div_res = dctl_q.special ? sres_q
                   : (dctl_q.is_rem ? rem_fix : quo_fix);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = div_req ? DIV : MUL;
            MUL:     if (mcnt_q == '0) state_d = DONE;
            DIV:     if (div_done | div_early) state_d = DONE;
            DONE:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE) & ~flush_i;
        resp_valid_o = (state_q == DONE);
        div_start    = accept & div_req;
        mul_fire     = (state_q == MUL) & (mcnt_q == '0) & ~flush_i;
        div_fire     = (state_q == DIV) & (div_done | div_early) & ~flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            mhi_q    <= 1'b0;
            mcnt_q   <= '0;
            dctl_q   <= '0;
            sres_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                tag_q  <= tag_i;
                ma_q   <= ma_d;
                mb_q   <= mb_d;
                mhi_q  <= (funct3_i != FUNCT3_MUL);
                mcnt_q <= MCW'(MUL_LAT - 1);
                dctl_q <= dctl_d;
                sres_q <= special_res;
            end
            if (state_q == MUL && mcnt_q != '0) mcnt_q <= mcnt_q - MCW'(1);
            if (mul_fire)
                result_q <= mhi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            if (div_fire) result_q <= div_res;
        end
    end

    assign result_o   = result_q;
    assign resp_tag_o = tag_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: directed vectors, latency,
// backpressure, flush and async reset.
`timescale 1ns/1ps
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;
    localparam int DL      = XLEN + 1;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam int DLE = 1;
`else
    localparam int DLE = XLEN + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             resp_ready = 1'b1;
    logic [XLEN-1:0]  op1 = '0;
    logic [XLEN-1:0]  op2 = '0;
    logic [2:0]       f3 = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             req_ready;
    logic             resp_valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] resp_tag;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_resp = 0;

    muldiv_iter_unit #(
        .XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .funct3_i    (f3),
        .tag_i       (tag),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .result_o    (result),
        .resp_tag_o  (resp_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic pv;
        int   rc;
        pv = 1'b0;
        rc = 0;
        forever begin
            @(negedge clk);
            if (resp_valid && !pv) rc = cyc;
            pv = resp_valid;
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: tag %0d result %0h, none outstanding",
                             resp_tag, result);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("tag", 64'(resp_tag), 64'(e.tag));
                    chk("latency", 64'(rc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] fn, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                         input logic [XLEN-1:0] er, input int lat,
                         input bit push);
        int n;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        f3 = fn; op1 = a; op2 = b; tag = t;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: tag %0d req_ready %0b required 1", t, req_ready);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (push) begin
                e.res = er; e.tag = t; e.lat = lat; e.acc = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: outstanding %0d required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int r0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_tag", 64'(resp_tag), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(FUNCT3_MUL,    32'hFFFFFFFE, 32'h3, 5'd1, 32'hFFFFFFFA, MUL_LAT, 1);
        issue(FUNCT3_MULH,   32'hFFFFFFFE, 32'h3, 5'd2, 32'hFFFFFFFF, MUL_LAT, 1);
        issue(FUNCT3_MULHU,  32'hFFFFFFFE, 32'h3, 5'd3, 32'h00000002, MUL_LAT, 1);
        issue(FUNCT3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h80000000, MUL_LAT, 1);
        issue(FUNCT3_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 5'd5, 32'h3FFFFFFF, MUL_LAT, 1);
        issue(FUNCT3_DIV,    32'hFFFFFFF9, 32'h2, 5'd6, 32'hFFFFFFFD, DL, 1);
        issue(FUNCT3_REM,    32'hFFFFFFF9, 32'h2, 5'd7, 32'hFFFFFFFF, DL, 1);
        issue(FUNCT3_DIVU,   32'd100, 32'd7, 5'd8, 32'd14, DL, 1);
        issue(FUNCT3_REMU,   32'd100, 32'd7, 5'd9, 32'd2, DL, 1);
        issue(FUNCT3_DIV,    32'd7, 32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, DL, 1);
        issue(FUNCT3_REM,    32'd7, 32'hFFFFFFFE, 5'd11, 32'd1, DL, 1);
        issue(FUNCT3_DIVU,   32'hFFFFFFFF, 32'd1, 5'd12, 32'hFFFFFFFF, DL, 1);
        issue(FUNCT3_DIV,    32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, DLE, 1);
        issue(FUNCT3_REMU,   32'd5, 32'd0, 5'd14, 32'd5, DLE, 1);
        issue(FUNCT3_REM,    32'hFFFFFFFB, 32'd0, 5'd15, 32'hFFFFFFFB, DLE, 1);
        issue(FUNCT3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, DLE, 1);
        issue(FUNCT3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, DLE, 1);
        issue(FUNCT3_DIVU,   32'd3, 32'd7, 5'd18, 32'd0, DLE, 1);
        issue(FUNCT3_REM,    32'hFFFFFFFD, 32'd7, 5'd19, 32'hFFFFFFFD, DLE, 1);
        issue(FUNCT3_DIVU,   32'd0, 32'd5, 5'd20, 32'd0, DLE, 1);
        drain();

        // backpressure
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(FUNCT3_MULHU, 32'hFFFFFFFE, 32'h3, 5'd7, 32'd2, MUL_LAT, 1);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(resp_valid), 64'd1);
        repeat (10) begin
            chk("bp_result", 64'(result), 64'd2);
            chk("bp_tag", 64'(resp_tag), 64'd7);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_same_cycle", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_ready_next", 64'(req_ready), 64'd1);
        chk("bp_valid_dropped", 64'(resp_valid), 64'd0);
        drain();

        // flush mid-DIVU with a concurrent request
        r0 = n_resp;
        issue(FUNCT3_DIVU, 32'd100, 32'd7, 5'd21, 32'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        req_valid = 1'b1;
        f3 = FUNCT3_MUL; op1 = 32'd5; op2 = 32'd5; tag = 5'd22;
        @(negedge clk);
        chk("flush_blocks_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_ready_next", 64'(req_ready), 64'd1);
        chk("flush_no_valid", 64'(resp_valid), 64'd0);
        repeat (45) @(negedge clk);
        chk("flush_no_resp", 64'(n_resp - r0), 64'd0);

        // async reset mid-DIV
        issue(FUNCT3_DIV, 32'hFFFFFFF9, 32'd2, 5'd23, 32'd0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_tag", 64'(resp_tag), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(FUNCT3_MUL, 32'd6, 32'd7, 5'd24, 32'd42, MUL_LAT, 1);
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
